pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
//  - Detects RAW hazards between ID-stage sources and the EXE/MEM destinations.
//  - Drives PC/IF-ID freeze, IF-ID flush, and the ID-EXE bubble (the ID-EXE register's flush input).
//  - Freezes the whole pipeline while a multi-cycle data-memory access waits.
//  - Keeps saturating performance counters and a sticky memory-timeout flag.
// PARAMETERS
//  CNT_W        16   width of the stall/wait performance counters
//  MEM_TIMEOUT  255  wait cycles in MEM_WAIT before mem_timeout is set (1..2^TO_W-1)
//  TO_W         8    width of the memory wait-cycle counter
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      reset, synchronous, active-high
//  forward_en      in   1      1 = forwarding unit present; only load-use stalls
//  id_src1         in   4      ID Rn index
//  id_use_src1     in   1      ID instruction reads Rn
//  id_src2         in   4      ID Rm/Rd(store) index
//  id_two_src      in   1      ID instruction reads src2
//  exe_dest        in   4      EXE-stage destination register
//  exe_wb_en       in   1      EXE-stage instruction writes back
//  exe_mem_r_en    in   1      EXE-stage instruction is a load
//  mem_dest        in   4      MEM-stage destination register
//  mem_wb_en       in   1      MEM-stage instruction writes back
//  exe_branch_tkn  in   1      EXE resolved a taken branch this cycle
//  mem_req         in   1      MEM stage holds a load/store (r_en | w_en)
//  mem_ready       in   1      data memory completes the access this cycle
//  pc_freeze       out  1      hold PC
//  ifid_freeze     out  1      hold IF-ID register
//  ifid_flush      out  1      clear IF-ID register
//  idex_flush      out  1      insert bubble into ID-EXE register
//  pipe_freeze     out  1      hold ID-EXE, EXE-MEM, MEM-WB registers
//  mem_timeout     out  1      sticky: a memory wait exceeded MEM_TIMEOUT
//  stall_cnt       out  CNT_W  cycles with a data-hazard stall (saturating)
//  memwait_cnt     out  CNT_W  cycles with pipe_freeze high (saturating)
// BEHAVIOUR
//  - Combinational terms:
//    - m1 = id_use_src1 & (id_src1 == D); m2 = id_two_src & (id_src2 == D).
//    - haz_exe = exe_wb_en & (m1|m2 with D = exe_dest) & (!forward_en | exe_mem_r_en).
//    - haz_mem = mem_wb_en & (m1|m2 with D = mem_dest) & !forward_en.
//    - hazard = haz_exe | haz_mem; mwait = mem_req & !mem_ready.
//  - Priority, combinational (zero latency), evaluated each cycle:
//    1. mwait: pipe_freeze = pc_freeze = ifid_freeze = 1; flushes = 0; branch and hazard ignored
//       (EXE is held, so the branch re-presents after release).
//    2. exe_branch_tkn: ifid_flush = idex_flush = 1; freezes = 0. A hazard in the same cycle
//       belongs to the wrong path and is dropped.
//    3. hazard: pc_freeze = ifid_freeze = idex_flush = 1.
//    4. Otherwise all control outputs 0.
//  - rst high: every output is 0 in that cycle, regardless of inputs.
//  - FSM states: RUN, MEM_WAIT.
//    - RUN -> MEM_WAIT on mwait.
//    - MEM_WAIT -> RUN when mem_ready or !mem_req.
//    - wait_ctr (TO_W bits): loaded with 1 on RUN -> MEM_WAIT; +1 per MEM_WAIT cycle; saturates.
//    - wait_ctr == MEM_TIMEOUT while in MEM_WAIT: mem_timeout <= 1 (sticky until rst).
//      The freeze continues until mem_ready.
//  - Counters, registered, 1-cycle latency:
//    - stall_cnt +1 in every cycle where priority-3 is active.
//    - memwait_cnt +1 in every cycle where pipe_freeze = 1.
//    - Both hold at 2^CNT_W-1.
//  - Reset, also mid-wait: state = RUN, wait_ctr = 0, mem_timeout = 0, counters = 0.
//  - Register R0 is an ordinary register for matching (no zero-register exemption).
// TESTING
//  - T1: forward_en=0, exe_dest=3, exe_wb_en=1, id_src1=3, id_use_src1=1
//    -> pc_freeze=ifid_freeze=idex_flush=1; stall_cnt=1 next cycle.
//  - T2: forward_en=1, same as T1 with exe_mem_r_en=0 -> no stall.
//    With exe_mem_r_en=1 -> 1-cycle stall.
//  - T3: hazard and exe_branch_tkn in the same cycle -> ifid_flush=idex_flush=1, pc_freeze=0,
//    stall_cnt unchanged.
//  - T4: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> pipe_freeze high for 4 cycles,
//    memwait_cnt=4, branch during the wait ignored.
//  - T5: MEM_TIMEOUT=3, mem_ready held 0 -> mem_timeout rises after the 3rd wait cycle.
//    It stays 1 after mem_ready; rst clears it.
//  - T6: rst asserted in MEM_WAIT, mem_req still 1 -> outputs 0 during rst.
//    Next cycle re-enters MEM_WAIT with wait_ctr=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/stall sequencer.
// The master side is the datapath; the slave side is pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             forward_en;
  logic [3:0]       id_src1;
  logic             id_use_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             exe_branch_tkn;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output forward_en, id_src1, id_use_src1, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           exe_branch_tkn, mem_req, mem_ready,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze,
           mem_timeout, stall_cnt, memwait_cnt
  );

  modport slave (
    input  forward_en, id_src1, id_use_src1, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
           exe_branch_tkn, mem_req, mem_ready,
    output pc_freeze, ifid_freeze, ifid_flush, idex_flush, pipe_freeze,
           mem_timeout, stall_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazard detection,
// branch flush, memory-wait freeze, wait timeout and performance counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_ctr_q, wait_ctr_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  logic m1_exe, m2_exe, m1_mem, m2_mem;
  logic haz_exe, haz_mem, hazard, mwait;
  logic pc_frz, ifid_frz, ifid_fl, idex_fl, pipe_frz, stall_act;

  always_comb begin
    m1_exe  = hz.id_use_src1 & (hz.id_src1 == hz.exe_dest);
    m2_exe  = hz.id_two_src  & (hz.id_src2 == hz.exe_dest);
    m1_mem  = hz.id_use_src1 & (hz.id_src1 == hz.mem_dest);
    m2_mem  = hz.id_two_src  & (hz.id_src2 == hz.mem_dest);
    // With forwarding only a load in EXE cannot be bypassed in time.
    haz_exe = hz.exe_wb_en & (m1_exe | m2_exe) & (~hz.forward_en | hz.exe_mem_r_en);
    haz_mem = hz.mem_wb_en & (m1_mem | m2_mem) & ~hz.forward_en;
    hazard  = haz_exe | haz_mem;
    mwait   = hz.mem_req & ~hz.mem_ready;
  end

  always_comb begin
    pc_frz    = 1'b0;
    ifid_frz  = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    pipe_frz  = 1'b0;
    stall_act = 1'b0;
    if (!rst) begin
      if (mwait) begin
        // EXE is held, so a pending branch re-presents after release.
        pipe_frz = 1'b1;
        pc_frz   = 1'b1;
        ifid_frz = 1'b1;
      end else if (hz.exe_branch_tkn) begin
        ifid_fl = 1'b1;
        idex_fl = 1'b1;
      end else if (hazard) begin
        pc_frz    = 1'b1;
        ifid_frz  = 1'b1;
        idex_fl   = 1'b1;
        stall_act = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_ctr_d    = wait_ctr_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    case (state_q)
      RUN: begin
        if (mwait) begin
          state_d    = MEM_WAIT;
          wait_ctr_d = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (wait_ctr_q == TO_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;
        if (!mwait) begin
          state_d    = RUN;
          wait_ctr_d = '0;
        end else if (wait_ctr_q != '1) begin
          wait_ctr_d = wait_ctr_q + TO_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (stall_act && stall_cnt_q != '1)  stall_cnt_d   = stall_cnt_q + CNT_W'(1);
    if (pipe_frz && memwait_cnt_q != '1) memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_ctr_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_ctr_q    <= wait_ctr_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  // Registered outputs are also forced low during the reset cycle itself.
  assign hz.pc_freeze   = pc_frz;
  assign hz.ifid_freeze = ifid_frz;
  assign hz.ifid_flush  = ifid_fl;
  assign hz.idex_flush  = idex_fl;
  assign hz.pipe_freeze = pipe_frz;
  assign hz.mem_timeout = mem_timeout_q & ~rst;
  assign hz.stall_cnt   = rst ? '0 : stall_cnt_q;
  assign hz.memwait_cnt = rst ? '0 : memwait_cnt_q;
endmodule
